framebuf_scanout_ctrl: RTL and testbench

- Sequences the display-side port (port 2) of the 8192x16 dual-port frame-buffer RAM for the voxel display.
- The RAM is split into two 4096-word banks by address bit 12. The host writes the back bank through port 1. This block streams one slice of the front bank per slice_tick to the LED shifter through a valid/ready interface.
- A host swap request takes effect only at a revolution boundary (index_pulse), so the display never shows a torn volume.

---
 rtl/framebuf_pkg.sv | 17 +
 rtl/framebuf_scanout_ctrl_if.sv | 14 +
 rtl/framebuf_skid_buf.sv | 45 ++++
 rtl/framebuf_scanout_ctrl.sv | 148 ++++++++++++++
 tb/tb_framebuf_scanout_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/framebuf_pkg.sv
// rtl/framebuf_pkg.sv - shared constants and state type for the frame-buffer scan-out block
package framebuf_pkg;

    localparam int FB_ADDR_W          = 13;
    localparam int FB_DATA_W          = 16;
    localparam int FB_WORDS_PER_SLICE = 32;
    localparam int FB_NUM_SLICES      = 128;
    localparam int SLICE_W            = $clog2(FB_NUM_SLICES);
    localparam int WORD_W             = $clog2(FB_WORDS_PER_SLICE);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } fb_state_e;

endpackage

// File: rtl/framebuf_scanout_ctrl_if.sv
// rtl/framebuf_scanout_ctrl_if.sv - pixel stream from the scan-out controller to the LED shifter
interface framebuf_scanout_ctrl_if
    import framebuf_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
    modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/framebuf_skid_buf.sv
// rtl/framebuf_skid_buf.sv - two-entry FIFO holding {last, data} between RAM read and pixel stream
module framebuf_skid_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    output logic [W-1:0] pop_data,
    input  logic         pop_ready,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = (count_q != 2'd0) && pop_ready;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_valid && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_valid = (count_q != 2'd0);
    assign pop_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/framebuf_scanout_ctrl.sv
// rtl/framebuf_scanout_ctrl.sv - streams one front-bank slice per slice_tick, swaps banks at index
module framebuf_scanout_ctrl
    import framebuf_pkg::*;
#(
    parameter int ADDR_W          = FB_ADDR_W,
    parameter int DATA_W          = FB_DATA_W,
    parameter int WORDS_PER_SLICE = FB_WORDS_PER_SLICE,
    parameter int NUM_SLICES      = FB_NUM_SLICES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    index_pulse,
    input  logic                    slice_tick,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    front_bank,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_chipselect,
    output logic                    mem_clken,
    output logic                    mem_write,
    input  logic [DATA_W-1:0]       mem_readdata,
    framebuf_scanout_ctrl_if.master pix
);
    localparam int SW = $clog2(NUM_SLICES);
    localparam int WW = $clog2(WORDS_PER_SLICE);

    if (WORDS_PER_SLICE * NUM_SLICES != (1 << (ADDR_W - 1))) begin : g_geom_check
        $error("framebuf_scanout_ctrl: WORDS_PER_SLICE*NUM_SLICES must equal 2**(ADDR_W-1)");
    end

    fb_state_e       state_q, state_d;
    logic            front_bank_q, front_bank_d;
    logic            swap_ack_q, swap_ack_d;
    logic            overrun_q, overrun_d;
    logic            index_pend_q, index_pend_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic [SW-1:0]   slice_idx_q, slice_idx_d;
    logic [WW-1:0]   word_idx_q, word_idx_d;

    logic [1:0]      occ;
    logic            pop;
    logic            issue;
    logic            head_last;
    logic [DATA_W-1:0] head_data;

    framebuf_skid_buf #(.W(DATA_W + 1)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_valid (inflight_q),
        .push_data  ({inflight_last_q, mem_readdata}),
        .pop_valid  (pix.pix_valid),
        .pop_data   ({head_last, head_data}),
        .pop_ready  (pix.pix_ready),
        .count      (occ)
    );

    assign pop = pix.pix_valid && pix.pix_ready;
    // Counting this cycle's pop lets a full-rate stream keep one word buffered and one in flight.
    assign issue = (state_q == STREAM) &&
                   (({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

    always_comb begin
        state_d         = state_q;
        front_bank_d    = front_bank_q;
        swap_ack_d      = 1'b0;
        overrun_d       = overrun_clr ? 1'b0 : overrun_q;
        index_pend_d    = index_pend_q;
        slice_idx_d     = slice_idx_q;
        word_idx_d      = word_idx_q;
        inflight_d      = issue;
        inflight_last_d = issue && (word_idx_q == WW'(WORDS_PER_SLICE - 1));

        if (state_q != IDLE) begin
            if (index_pulse) index_pend_d = 1'b1;
            if (slice_tick)  overrun_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (index_pend_q || index_pulse) begin
                    slice_idx_d  = '0;
                    index_pend_d = 1'b0;
                    if (swap_req) begin
                        front_bank_d = ~front_bank_q;
                        swap_ack_d   = 1'b1;
                    end
                end
                if (slice_tick) begin
                    state_d    = STREAM;
                    word_idx_d = '0;
                end
            end
            STREAM: begin
                if (issue) begin
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == WW'(WORDS_PER_SLICE - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    slice_idx_d = slice_idx_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            front_bank_q    <= 1'b0;
            swap_ack_q      <= 1'b0;
            overrun_q       <= 1'b0;
            index_pend_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            slice_idx_q     <= '0;
            word_idx_q      <= '0;
        end else begin
            state_q         <= state_d;
            front_bank_q    <= front_bank_d;
            swap_ack_q      <= swap_ack_d;
            overrun_q       <= overrun_d;
            index_pend_q    <= index_pend_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            slice_idx_q     <= slice_idx_d;
            word_idx_q      <= word_idx_d;
        end
    end

    assign mem_address    = {front_bank_q, slice_idx_q, word_idx_q};
    assign mem_chipselect = issue;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign swap_ack       = swap_ack_q;
    assign front_bank     = front_bank_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != IDLE);
    assign pix.pix_data   = head_data;
    assign pix.pix_last   = pix.pix_valid && head_last;

endmodule

// File: tb/tb_framebuf_scanout_ctrl.sv
// tb/tb_framebuf_scanout_ctrl.sv - randomized bench for framebuf_scanout_ctrl against a slice-level model
module tb_framebuf_scanout_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        index_pulse = 1'b0;
    logic        slice_tick = 1'b0;
    logic        swap_req = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        swap_ack, front_bank, overrun, busy;
    logic [12:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [15:0] mem_readdata = 16'h0;

    framebuf_scanout_ctrl_if #(.DATA_W(16)) pif ();

    framebuf_scanout_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .index_pulse    (index_pulse),
        .slice_tick     (slice_tick),
        .swap_req       (swap_req),
        .swap_ack       (swap_ack),
        .front_bank     (front_bank),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr),
        .busy           (busy),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .pix            (pif.master)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [8192];
    always @(posedge clk) if (mem_chipselect) mem_readdata <= ram[mem_address];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slice-level model: which word comes next, from which bank and slice.
    logic        m_busy, m_bank, m_pend, m_ovr, m_ack;
    logic [6:0]  m_slice;
    int          m_iss, m_acc;
    logic        prev_hold, prev_last;
    logic [15:0] prev_data;
    logic        acc_now;
    logic [12:0] exp_addr;
    int          cyc = 0;
    int          tick_cyc, first_cs_cyc, last_cs_cyc, first_valid_cyc, slice_acc;
    logic [12:0] first_cs_addr, last_cs_addr;
    logic        seen_cs, seen_valid;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_bank = 0; m_pend = 0; m_ovr = 0; m_ack = 0;
            m_slice = 0; m_iss = 0; m_acc = 0; prev_hold = 0;
        end else begin
            acc_now = pif.pix_valid && pif.pix_ready;
            check("busy", busy, m_busy);
            check("front_bank", front_bank, m_bank);
            check("swap_ack", swap_ack, m_ack);
            check("overrun", overrun, m_ovr);
            check("clken_write", {mem_clken, mem_write}, 2'b10);
            if (!m_busy) check("valid_idle", pif.pix_valid, 1'b0);
            if (prev_hold) begin
                check("hold_valid", pif.pix_valid, 1'b1);
                check("hold_data", pif.pix_data, prev_data);
                check("hold_last", pif.pix_last, prev_last);
            end
            if (mem_chipselect) begin
                exp_addr = {m_bank, m_slice, 5'(m_iss)};
                check("cs_legal", m_busy && (m_iss < 32), 1'b1);
                check("addr", mem_address, exp_addr);
                check("ahead", (m_iss + 1 - m_acc - int'(acc_now)) <= 2, 1'b1);
                if (!seen_cs) begin first_cs_cyc = cyc; first_cs_addr = mem_address; seen_cs = 1; end
                last_cs_cyc  = cyc;
                last_cs_addr = mem_address;
            end
            if (pif.pix_valid && !seen_valid && m_busy) begin first_valid_cyc = cyc; seen_valid = 1; end
            if (acc_now) begin
                check("acc_busy", m_busy, 1'b1);
                check("pix_data", pif.pix_data, ram[{m_bank, m_slice, 5'(m_acc)}]);
                check("pix_last", pif.pix_last, m_acc == 31);
                slice_acc++;
            end
            prev_hold = pif.pix_valid && !pif.pix_ready;
            prev_data = pif.pix_data;
            prev_last = pif.pix_last;

            m_ack = 0;
            if (overrun_clr) m_ovr = 0;
            if (m_busy) begin
                if (index_pulse) m_pend = 1;
                if (slice_tick)  m_ovr  = 1;
                if (mem_chipselect) m_iss++;
                if (acc_now) begin
                    if (m_acc == 31) begin m_busy = 0; m_slice = m_slice + 7'd1; end
                    m_acc++;
                end
            end else begin
                if (m_pend || index_pulse) begin
                    m_slice = 0; m_pend = 0;
                    if (swap_req) begin m_bank = ~m_bank; m_ack = 1; end
                end
                if (slice_tick) begin
                    m_busy = 1; m_iss = 0; m_acc = 0;
                    tick_cyc = cyc; seen_cs = 0; seen_valid = 0; slice_acc = 0;
                end
            end
        end
    end

    int rdy_mode = 0;
    initial begin
        pif.pix_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       pif.pix_ready = 1'b1;
                1:       pif.pix_ready = ~pif.pix_ready;
                default: pif.pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic next();
        @(posedge clk); #2;
    endtask

    task automatic pulse_tick();
        slice_tick = 1'b1; next(); slice_tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin next(); n++; end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic index_swap(input logic sw);
        swap_req = sw; index_pulse = 1'b1; next(); index_pulse = 1'b0; swap_req = 1'b0;
    endtask

    initial begin
        int n;
        logic saw_ack;
        for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
        repeat (3) next();
        reset = 1'b0;
        next();
        check("rst_busy", busy, 1'b0);
        check("rst_bank", front_bank, 1'b0);
        check("rst_ack", swap_ack, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_cs", mem_chipselect, 1'b0);
        check("rst_valid", pif.pix_valid, 1'b0);
        check("rst_last", pif.pix_last, 1'b0);
        check("rst_addr", mem_address, 13'h0000);
        check("rst_clken", mem_clken, 1'b1);

        rdy_mode = 0;
        pulse_tick();
        wait_idle(500);
        check("s0_first_addr", first_cs_addr, 13'h0000);
        check("s0_last_addr", last_cs_addr, 13'h001F);
        check("s0_cs_span", last_cs_cyc - first_cs_cyc, 31);
        check("s0_cs_lat", first_cs_cyc - tick_cyc, 1);
        check("s0_valid_lat", first_valid_cyc - first_cs_cyc, 2);
        check("s0_accepts", slice_acc, 32);
        check("s0_next_slice", mem_address, 13'h0020);

        rdy_mode = 1;
        pulse_tick();
        wait_idle(500);
        check("s1_first_addr", first_cs_addr, 13'h0020);
        check("s1_accepts", slice_acc, 32);

        rdy_mode = 0;
        index_swap(1'b1);
        check("swap_ack_pulse", swap_ack, 1'b1);
        check("swap_bank", front_bank, 1'b1);
        next();
        check("swap_ack_drop", swap_ack, 1'b0);
        pulse_tick();
        wait_idle(500);
        check("swap_first_addr", first_cs_addr, 13'h1000);

        index_swap(1'b1);
        rdy_mode = 2;
        for (int s = 0; s < 5; s++) begin pulse_tick(); wait_idle(500); end
        pulse_tick();
        repeat (4) next();
        swap_req = 1'b1; index_pulse = 1'b1; next(); index_pulse = 1'b0;
        saw_ack = 1'b0; n = 0;
        while (!saw_ack && n < 500) begin
            if (swap_ack) saw_ack = 1'b1; else begin next(); n++; end
        end
        swap_req = 1'b0;
        check("s5_ack_seen", saw_ack, 1'b1);
        check("s5_first_addr", first_cs_addr, 13'h00A0);
        check("s5_last_addr", last_cs_addr, 13'h00BF);
        check("s5_accepts", slice_acc, 32);
        rdy_mode = 0;
        pulse_tick();
        wait_idle(500);
        check("s5_after_addr", first_cs_addr, 13'h1000);

        pulse_tick();
        repeat (9) next();
        pulse_tick();
        check("ovr_set", overrun, 1'b1);
        wait_idle(500);
        check("ovr_accepts", slice_acc, 32);
        overrun_clr = 1'b1; next(); overrun_clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);

        index_swap(1'b1);
        for (int s = 0; s < 128; s++) begin
            pulse_tick();
            wait_idle(500);
            if (s == 127) check("wrap_last_slice", first_cs_addr, 13'h0FE0);
        end
        pulse_tick();
        wait_idle(500);
        check("wrap_first_addr", first_cs_addr, 13'h0000);

        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            slice_tick  = ($urandom_range(0, 19) == 0);
            index_pulse = ($urandom_range(0, 99) == 0);
            overrun_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) swap_req = ~swap_req;
            next();
        end
        slice_tick = 0; index_pulse = 0; overrun_clr = 0; swap_req = 0;
        wait_idle(500);

        rdy_mode = 0;
        pulse_tick();
        repeat (6) next();
        reset = 1'b1;
        repeat (2) next();
        reset = 1'b0;
        next();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", pif.pix_valid, 1'b0);
        pulse_tick();
        wait_idle(500);
        check("mid_rst_first", first_cs_addr, 13'h0000);
        check("mid_rst_accepts", slice_acc, 32);

        repeat (3) next();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
